// File: rtl/mpeg_bit_packer_if.sv
// Field-in / word-out handshake bundle for mpeg_bit_packer.
// slave is the packer side, master is the producer/consumer side.
interface mpeg_bit_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        flush_done;
  logic        busy;

  modport slave (
    input  in_valid, in_data, in_len, flush, out_ready,
    output in_ready, out_valid, out_data, out_last, flush_done, busy
  );

  modport master (
    output in_valid, in_data, in_len, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, flush_done, busy
  );
endinterface

// File: rtl/mpeg_bit_packer.sv
// Variable-length MSB-first bitstream writer: packs 1..32-bit fields into 32-bit words,
// optionally byte-swapped, with a flush that zero-pads and tags the final word.
module mpeg_bit_packer #(
  parameter int unsigned BYTE_SWAP = 1
) (
  input logic              clk,
  input logic              reset_n,
  mpeg_bit_packer_if.slave bus
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [63:0] acc_q, acc_d;
  logic [6:0]  fill_q, fill_d;
  logic [1:0]  state_q, state_d;
  logic        flush_pending_q, flush_pending_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;

  logic [6:0]  len_eff;
  logic [6:0]  fill_ext;
  logic [6:0]  shamt;
  logic [63:0] mask;
  logic [63:0] field;
  logic [63:0] acc_ext;
  logic [31:0] word_be;
  logic [31:0] word_out;
  logic        accept;
  logic        load_ok;
  logic        ext_full;
  logic        ext_part;
  logic        extract;

  assign bus.in_ready = (state_q == StRun) && !flush_pending_q && (fill_q <= 7'd32);

  assign len_eff = (bus.in_len > 6'd32) ? 7'd32 : {1'b0, bus.in_len};
  // len 0 yields a 32-bit shift, i.e. an all-zero mask
  assign mask    = 64'h0000_0000_FFFF_FFFF >> (7'd32 - len_eff);
  assign field   = {32'h0, bus.in_data} & mask;
  assign accept  = bus.in_valid && bus.in_ready;
  assign load_ok = !out_valid_q || bus.out_ready;

  // Extraction decisions use fill before this cycle's append
  assign ext_full = load_ok && (fill_q >= 7'd32);
  assign ext_part = load_ok && (state_q == StFlush) && (fill_q != 7'd0) && (fill_q < 7'd32);
  assign extract  = ext_full || ext_part;

  assign fill_ext = ext_full ? (fill_q - 7'd32) : (ext_part ? 7'd0 : fill_q);
  assign acc_ext  = extract ? {acc_q[31:0], 32'h0} : acc_q;
  // Append position is taken relative to the already-shifted accumulator
  assign shamt    = 7'd64 - fill_ext - len_eff;

  assign word_be  = acc_q[63:32];
  assign word_out = (BYTE_SWAP != 0) ?
                    {word_be[7:0], word_be[15:8], word_be[23:16], word_be[31:24]} : word_be;

  always_comb begin
    acc_d  = acc_ext | (accept ? (field << shamt) : 64'h0);
    fill_d = fill_ext + (accept ? len_eff : 7'd0);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (extract) begin
      out_valid_d = 1'b1;
      out_data_d  = word_out;
      out_last_d  = flush_pending_q && (fill_ext == 7'd0);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    case (state_q)
      StRun: begin
        if (bus.flush) flush_pending_d = 1'b1;
        if (flush_pending_q) state_d = StFlush;
      end
      StFlush: begin
        if ((fill_q == 7'd0) && load_ok) state_d = StDone;
      end
      StDone: begin
        flush_pending_d = 1'b0;
        state_d         = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q           <= 64'h0;
      fill_q          <= 7'd0;
      state_q         <= StRun;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= 32'h0;
      out_last_q      <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      fill_q          <= fill_d;
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.flush_done = (state_q == StDone);
  assign bus.busy       = (fill_q != 7'd0) || out_valid_q || (state_q != StRun);

endmodule

// File: tb/tb_mpeg_bit_packer.sv
// Bench for mpeg_bit_packer: two instances (BYTE_SWAP 0 and 1) share one stimulus; a
// vector table, hand-written corner sequences and a bit-queue model cover behaviour.
module tb_mpeg_bit_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, flush, out_ready_v;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        rand_rdy, rdy_fixed;

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;

  logic [31:0] got_dn[$], got_ds[$], exp_w[$];
  logic        got_ln[$], got_ls[$];
  bit          exp_l[$];
  bit          model_bits[$];

  mpeg_bit_packer_if bn ();
  mpeg_bit_packer_if bs ();

  assign bn.in_valid = in_valid;
  assign bn.in_data = in_data;
  assign bn.in_len = in_len;
  assign bn.flush = flush;
  assign bn.out_ready = out_ready_v;
  assign bs.in_valid = in_valid;
  assign bs.in_data = in_data;
  assign bs.in_len = in_len;
  assign bs.flush = flush;
  assign bs.out_ready = out_ready_v;

  mpeg_bit_packer #(.BYTE_SWAP(0)) dut_n (.clk(clk), .reset_n(reset_n), .bus(bn));
  mpeg_bit_packer #(.BYTE_SWAP(1)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bs));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready_v <= rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  always @(negedge clk) begin
    if (bn.out_valid && bn.out_ready) begin
      got_dn.push_back(bn.out_data);
      got_ln.push_back(bn.out_last);
      got_ds.push_back(bs.out_data);
      got_ls.push_back(bs.out_last);
    end
    if (bn.flush_done) fd_cnt <= fd_cnt + 1;
  end

  function automatic logic [31:0] sw(logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  function automatic void check_got(string nm);
    chk({nm, "_count"}, 32'(got_dn.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_dn.size(); i++) begin
      chk({nm, "_word"}, got_dn[i], exp_w[i]);
      chk({nm, "_swap"}, got_ds[i], sw(exp_w[i]));
      chk({nm, "_last"}, {31'b0, got_ln[i]}, {31'b0, exp_l[i]});
      chk({nm, "_last_s"}, {31'b0, got_ls[i]}, {31'b0, exp_l[i]});
    end
    got_dn.delete(); got_ds.delete(); got_ln.delete(); got_ls.delete();
    exp_w.delete(); exp_l.delete();
  endfunction

  // Reference: the stream as a flat bit list, cut into words every 32 bits
  function automatic void model_push(logic [31:0] d, logic [5:0] l);
    int eff;
    logic [31:0] w;
    eff = (l > 6'd32) ? 32 : int'(l);
    for (int i = eff - 1; i >= 0; i--) model_bits.push_back(d[i]);
    while (model_bits.size() >= 32) begin
      for (int i = 31; i >= 0; i--) w[i] = model_bits.pop_front();
      exp_w.push_back(w);
      exp_l.push_back(1'b0);
    end
  endfunction

  function automatic void model_flush();
    logic [31:0] w;
    if (model_bits.size() > 0) begin
      while (model_bits.size() < 32) model_bits.push_back(1'b0);
      for (int i = 31; i >= 0; i--) w[i] = model_bits.pop_front();
      exp_w.push_back(w);
      exp_l.push_back(1'b1);
    end else if (exp_l.size() > 0) begin
      exp_l[exp_l.size() - 1] = 1'b1;
    end
  endfunction

  task automatic push(input logic [31:0] d, input logic [5:0] l, input bit fl);
    int n = 0;
    while (!bn.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("push_ready", {31'b0, bn.in_ready}, 32'd1);
    if (bn.in_ready) begin
      in_valid = 1'b1; in_data = d; in_len = l; flush = fl;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; in_len = '0; flush = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_fd(input int prev);
    int n = 0;
    while (fd_cnt == prev && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("flush_done_seen", {31'b0, fd_cnt != prev}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bn.busy && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("busy_idle", {31'b0, bn.busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, {30'b0, bn.out_valid, bs.out_valid}, 32'd0);
    chk({nm, "_data"}, bn.out_data | bs.out_data, 32'd0);
    chk({nm, "_last"}, {30'b0, bn.out_last, bs.out_last}, 32'd0);
    chk({nm, "_done"}, {30'b0, bn.flush_done, bs.flush_done}, 32'd0);
    chk({nm, "_busy"}, {30'b0, bn.busy, bs.busy}, 32'd0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] d[3];
    logic [5:0]  l[3];
    bit          fl;
    int          nw;
    logic [31:0] w[2];
  } vec_t;

  vec_t tbl[6];

  initial begin
    int prev;
    bit stall_ok;
    bit ready_seen;
    int n;
    int nf;
    logic [31:0] d;
    logic [5:0]  l;

    tbl[0] = '{3, '{32'hAB, 32'hCD, 32'h1234}, '{6'd8, 6'd8, 6'd16}, 1'b0, 1,
               '{32'hABCD1234, 32'h0}};
    tbl[1] = '{2, '{32'h1FFFFFF, 32'hABC, 32'h0}, '{6'd25, 6'd12, 6'd0}, 1'b1, 2,
               '{32'hFFFFFFD5, 32'hE0000000}};
    tbl[2] = '{1, '{32'h3, 32'h0, 32'h0}, '{6'd2, 6'd0, 6'd0}, 1'b1, 1,
               '{32'hC0000000, 32'h0}};
    tbl[3] = '{1, '{32'hDEADBEEF, 32'h0, 32'h0}, '{6'd32, 6'd0, 6'd0}, 1'b1, 1,
               '{32'hDEADBEEF, 32'h0}};
    tbl[4] = '{3, '{32'h12345678, 32'hFFFF, 32'h5}, '{6'd40, 6'd0, 6'd3}, 1'b1, 2,
               '{32'h12345678, 32'hA0000000}};
    tbl[5] = '{3, '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF}, '{6'd31, 6'd2, 6'd1}, 1'b1, 2,
               '{32'hFFFFFFFE, 32'h40000000}};

    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_len = '0; flush = 1'b0;
    rand_rdy = 1'b0; rdy_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      prev = fd_cnt;
      for (int j = 0; j < tbl[t].n; j++)
        push(tbl[t].d[j], tbl[t].l[j], tbl[t].fl && (j == tbl[t].n - 1));
      if (tbl[t].fl) wait_fd(prev);
      else wait_idle();
      for (int k = 0; k < tbl[t].nw; k++) begin
        exp_w.push_back(tbl[t].w[k]);
        exp_l.push_back(tbl[t].fl && (k == tbl[t].nw - 1));
      end
      check_got($sformatf("vec%0d", t));
    end

    // Field first, separate flush pulse later
    push(32'hFFFFFFF5, 6'd4, 1'b0);
    prev = fd_cnt;
    pulse_flush();
    wait_fd(prev);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_pulse_once", 32'(fd_cnt - prev), 32'd1);
    chk("ready_after_flush", {31'b0, bn.in_ready}, 32'd1);
    exp_w.push_back(32'h50000000); exp_l.push_back(1'b1);
    check_got("sep_flush");

    // Flush with nothing buffered: done pulse, no word
    prev = fd_cnt;
    pulse_flush();
    wait_fd(prev);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_flush_once", 32'(fd_cnt - prev), 32'd1);
    check_got("empty_flush");

    // Same-cycle field + flush; in_ready stays low and a second flush is ignored
    prev = fd_cnt;
    push(32'h3, 6'd2, 1'b1);
    ready_seen = 1'b0;
    n = 0;
    while (fd_cnt == prev && n < 100) begin
      if (bn.in_ready) ready_seen = 1'b1;
      flush = (n == 2);
      @(posedge clk); #1; n++;
    end
    flush = 1'b0;
    chk("no_ready_in_flush", {31'b0, ready_seen}, 32'd0);
    chk("same_cycle_fd", {31'b0, fd_cnt != prev}, 32'd1);
    chk("ready_after_done", {31'b0, bn.in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("second_flush_ignored", 32'(fd_cnt - prev), 32'd1);
    exp_w.push_back(32'hC0000000); exp_l.push_back(1'b1);
    check_got("same_cycle");

    // Backpressure: three 32-bit fields fit, the fourth stalls
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) push(32'hFFFFFFFF, 6'd32, 1'b0);
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_len = 6'd32;
    stall_ok = 1'b1;
    repeat (4) begin
      if (bn.in_ready) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("fourth_stalls", {31'b0, stall_ok}, 32'd1);
    chk("bp_out_valid", {31'b0, bn.out_valid}, 32'd1);
    rdy_fixed = 1'b1;
    wait_idle();
    for (int j = 0; j < 3; j++) begin
      exp_w.push_back(32'hFFFFFFFF); exp_l.push_back(1'b0);
    end
    check_got("backpressure");

    // Reset while flushing with a word held at the output
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    push(32'h1, 6'd4, 1'b1);
    n = 0;
    while (!bn.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("held_word_valid", {31'b0, bn.out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    rdy_fixed = 1'b1;
    @(posedge clk); #1;
    got_dn.delete(); got_ds.delete(); got_ln.delete(); got_ls.delete();
    prev = fd_cnt;
    push(32'hAB, 6'd8, 1'b1);
    wait_fd(prev);
    exp_w.push_back(32'hAB000000); exp_l.push_back(1'b1);
    check_got("after_reset");

    // Random segments with random output backpressure against the bit-list model
    rand_rdy = 1'b1;
    for (int s = 0; s < 40; s++) begin
      prev = fd_cnt;
      nf = $urandom_range(1, 5);
      for (int j = 0; j < nf; j++) begin
        d = $urandom;
        l = (j == nf - 1) ? 6'($urandom_range(1, 63)) : 6'($urandom_range(0, 63));
        model_push(d, l);
        push(d, l, j == nf - 1);
      end
      model_flush();
      wait_fd(prev);
      check_got($sformatf("rand%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
